muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Hardwired control sequencer for the 32-bit bus datapath. It fetches one instruction (T0–T2) and executes three-register ALU, MUL and DIV instructions (T3–T6). It drives the datapath's register-file one-hot strobes, the Y/Z/HI/LO strobes, the PC/MAR/MDR/IR strobes and ALU_opcode. It sits beside the datapath and replaces bench-driven control sequencing.

Parameters:
ALU_OP_MAX, 5'b01110, highest opcode treated as a single-result ALU op (range 0..ALU_OP_MAX)
MUL_OP, 5'b01111, multiply opcode; 64-bit result goes to HI/LO
DIV_OP, 5'b10000, divide opcode; quotient goes to LO, remainder to HI

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
run  in  1  level; high = keep issuing instructions
mem_wait  in  1  memory not ready; stretches T1
IR  in  32  instruction register contents; fields [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
Rin  out  16  one-hot register-file write strobes (R0in..R15in)
Rout  out  16  one-hot register-file read strobes (R0out..R15out)
PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin  out  1 each  fetch strobes
Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin  out  1 each  execute strobes
ALU_opcode  out  5  ALU operation select
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on the final execute cycle
illegal  out  1  one-cycle pulse when the opcode is unsupported

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. State register in clk domain. Outputs are Moore-decoded from the state and IR. Every unlisted strobe is 0.
- Reset: clr high at a clock edge forces IDLE from any state, including mid-instruction. All outputs are 0 while in IDLE. No write strobes are issued after reset.
- IDLE: run=1 -> T0; otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, ZLOin -> T1.
- T1: MDRread is held for the whole state.
  - mem_wait=1: stay in T1; PCin=0, MDRin=0.
  - mem_wait=0: ZLOout, PCin, MDRin for exactly one cycle -> T2.
  - PCin fires once per fetch, regardless of stall length.
- T2: MDRout, IRin -> T3. The IR value becomes valid in T3.
- T3: decode IR[31:27].
  - Unsupported opcode (> DIV_OP): illegal=1, no strobes -> IDLE; no register, HI or LO write.
  - Otherwise: Rout[Rb], Yin -> T4.
- T4: Rout[Rc], ZLOin, ZHIin, ALU_opcode=IR[31:27] -> T5. ALU_opcode is 0 in all other states.
- T5:
  - ALU op: ZLOout, Rin[Ra], done=1. Next state T0 if run=1, else IDLE.
  - MUL/DIV: ZLOout, Loin -> T6.
- T6 (MUL/DIV only): ZHIout, HIin, done=1. Next state T0 if run=1, else IDLE.
- Latency from T0: ALU op 6 cycles, MUL/DIV 7 cycles, plus any mem_wait cycles.
- Back-to-back: with run held high, T0 of the next instruction follows the done cycle with no IDLE gap.
- run is sampled only in IDLE and on the done cycle. Dropping run mid-instruction does not abort it.
- Rin and Rout have at most one bit set. A bus driver (Rout, PCout, MDRout, ZLOout, ZHIout) is asserted in at most one position per cycle.
- Ra=0 and Rb=0 are legal and decode to bit 0.
- mem_wait is ignored outside T1.

Test Plan:
- ALU add: IR op=5'b00011, Ra=2, Rb=6, Rc=7, run=1 for one cycle -> T0..T5 in 6 cycles; Rout=16'h0040 in T3; Rout=16'h0080 and ALU_opcode=3 in T4; Rin=16'h0004 and done=1 in T5; then IDLE.
- DIV: op=5'b10000, Rb=6, Rc=7 -> Loin with ZLOout in T5; HIin with ZHIout and done in T6; Rin stays 0 for the whole instruction; 7 cycles total.
- Memory stall: mem_wait=1 for 3 cycles in T1 -> T1 lasts 4 cycles; MDRread high all 4; PCin and MDRin each high exactly 1 cycle (the last).
- Illegal opcode: op=5'b11111 -> illegal=1 in T3; no Yin, Rin, Loin or HIin pulse; IDLE on the next cycle.
- Back-to-back: run held high through MUL then ALU instructions -> T0 of the ALU instruction directly follows T6; busy never drops.
- Reset mid-op: clr=1 during T4 of a MUL -> IDLE on the next edge with all outputs 0; no Loin or HIin ever asserted; a later run=1 restarts cleanly at T0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - hardwired fetch/execute control sequencer for ALU, MUL and DIV instructions
//
// Ports:
//   clk, clr           clock, synchronous active-high reset
//   run, mem_wait      issue enable (level), memory-not-ready stall for T1
//   IR                 instruction: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   Rin, Rout          one-hot register-file write / read strobes
//   PCout..IRin        fetch strobes
//   Yin..HIin          execute strobes
//   ALU_opcode         ALU operation select, only non-zero in T4
//   busy, done, illegal  status: not idle, final execute cycle, unsupported opcode
module muldiv_sequencer #(
    parameter logic [4:0] ALU_OP_MAX = 5'b01110,
    parameter logic [4:0] MUL_OP     = 5'b01111,
    parameter logic [4:0] DIV_OP     = 5'b10000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_wait,
    input  logic [31:0] IR,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRread,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLOin,
    output logic        ZHIin,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        Loin,
    output logic        HIin,
    output logic [4:0]  ALU_opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t state;

    logic [4:0]  op;
    logic [15:0] ra_hot;
    logic [15:0] rb_hot;
    logic [15:0] rc_hot;
    logic        is_alu;
    logic        is_muldiv;
    logic        unused_ir;

    assign op        = IR[31:27];
    assign ra_hot    = 16'h0001 << IR[26:23];
    assign rb_hot    = 16'h0001 << IR[22:19];
    assign rc_hot    = 16'h0001 << IR[18:15];
    assign is_alu    = (op <= ALU_OP_MAX);
    assign is_muldiv = (op == MUL_OP) || (op == DIV_OP);
    assign unused_ir = ^IR[14:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (!mem_wait) state <= S_T2;
                S_T2:   state <= S_T3;
                // Anything above DIV_OP aborts before any operand is driven.
                S_T3:   state <= (op > DIV_OP) ? S_IDLE : S_T4;
                S_T4:   state <= S_T5;
                S_T5: begin
                    if (is_alu) state <= run ? S_T0 : S_IDLE;
                    else        state <= S_T6;
                end
                S_T6:   state <= run ? S_T0 : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the state and the loaded IR. T1 additionally
    // looks at mem_wait so PCin/MDRin land only on the cycle the data arrives,
    // which keeps them to a single pulse however long the stall lasts.
    always_comb begin
        Rin        = 16'h0000;
        Rout       = 16'h0000;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRread    = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLOin      = 1'b0;
        ZHIin      = 1'b0;
        ZLOout     = 1'b0;
        ZHIout     = 1'b0;
        Loin       = 1'b0;
        HIin       = 1'b0;
        ALU_opcode = 5'd0;
        done       = 1'b0;
        illegal    = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                ZLOin = 1'b1;
            end
            S_T1: begin
                MDRread = 1'b1;
                if (!mem_wait) begin
                    ZLOout = 1'b1;
                    PCin   = 1'b1;
                    MDRin  = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (op > DIV_OP) begin
                    illegal = 1'b1;
                end else begin
                    Rout = rb_hot;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Rout       = rc_hot;
                ZLOin      = 1'b1;
                ZHIin      = 1'b1;
                ALU_opcode = op;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_alu) begin
                    Rin  = ra_hot;
                    done = 1'b1;
                end else if (is_muldiv) begin
                    Loin = 1'b1;
                end
            end
            S_T6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, mem_wait;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin;
    logic        Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin;
    logic [4:0]  ALU_opcode;
    logic        busy, done, illegal;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .mem_wait(mem_wait), .IR(IR),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .ZLOin(ZLOin), .ZHIin(ZHIin), .ZLOout(ZLOout),
        .ZHIout(ZHIout), .Loin(Loin), .HIin(HIin),
        .ALU_opcode(ALU_opcode), .busy(busy), .done(done), .illegal(illegal)
    );

    // fetch group {PCout,PCin,IncPC,MARin,MDRin,MDRread,MDRout,IRin}
    localparam logic [7:0] F_T0   = 8'b1011_0000;
    localparam logic [7:0] F_T1W  = 8'b0000_0100;
    localparam logic [7:0] F_T1   = 8'b0100_1100;
    localparam logic [7:0] F_T2   = 8'b0000_0011;
    // execute group {Yin,ZLOin,ZHIin,ZLOout,ZHIout,Loin,HIin}
    localparam logic [6:0] E_T0   = 7'b0100000;
    localparam logic [6:0] E_T1   = 7'b0001000;
    localparam logic [6:0] E_T3   = 7'b1000000;
    localparam logic [6:0] E_T4   = 7'b0110000;
    localparam logic [6:0] E_T5A  = 7'b0001000;
    localparam logic [6:0] E_T5M  = 7'b0001010;
    localparam logic [6:0] E_T6   = 7'b0000101;
    // flags {busy,done,illegal}
    localparam logic [2:0] BUSY   = 3'b100;
    localparam logic [2:0] DONE   = 3'b110;
    localparam logic [2:0] ILL    = 3'b101;

    localparam logic [31:0] I_ADD   = {5'b00011, 4'd2,  4'd6, 4'd7,  15'd0};
    localparam logic [31:0] I_DIV   = {5'b10000, 4'd3,  4'd6, 4'd7,  15'd0};
    localparam logic [31:0] I_ZERO  = {5'b00000, 4'd0,  4'd0, 4'd15, 15'd0};
    localparam logic [31:0] I_ILL   = {5'b11111, 4'd1,  4'd2, 4'd3,  15'd0};
    localparam logic [31:0] I_ILL2  = {5'b10001, 4'd4,  4'd5, 4'd6,  15'd0};
    localparam logic [31:0] I_MUL   = {5'b01111, 4'd15, 4'd1, 4'd2,  15'd0};
    localparam logic [31:0] I_AMAX  = {5'b01110, 4'd15, 4'd9, 4'd10, 15'd0};
    localparam logic [31:0] I_MUL2  = {5'b01111, 4'd5,  4'd8, 4'd11, 15'd0};

    typedef struct {
        logic        ill;
        logic [15:0] rin;
        int          cycles;
        int          lo;
        int          hi;
        int          rw;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int tot_lo = 0;
    int tot_hi = 0;
    int m_cyc = 0, m_lo = 0, m_hi = 0, m_rw = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] snap();
        return {PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin,
                Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin,
                Rin, Rout, ALU_opcode, busy, done, illegal};
    endfunction

    function automatic logic [54:0] mk(input logic [7:0] f, input logic [6:0] e,
                                       input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [4:0] alu, input logic [2:0] fl);
        return {f, e, rin, rout, alu, fl};
    endfunction

    // Completion monitor: latency from T0 and per-instruction write-strobe counts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (PCout) begin
                m_cyc = 0; m_lo = 0; m_hi = 0; m_rw = 0;
            end
            if (busy) m_cyc++;
            m_lo   += int'(Loin);
            m_hi   += int'(HIin);
            m_rw   += int'(Rin != 16'h0000);
            tot_lo += int'(Loin);
            tot_hi += int'(HIin);
            if (done || illegal) begin
                check("sb_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_kind",   64'(illegal), 64'(e.ill));
                    check("sb_rin",    64'(Rin),     64'(e.rin));
                    check("sb_cycles", 64'(m_cyc),   64'(e.cycles));
                    check("sb_lo",     64'(m_lo),    64'(e.lo));
                    check("sb_hi",     64'(m_hi),    64'(e.hi));
                    check("sb_rwrite", 64'(m_rw),    64'(e.rw));
                end
            end
        end
    end

    // Drives one instruction and checks every cycle of it. Called either at a
    // negedge in IDLE (b2b=0) or at the negedge of the previous done cycle
    // with run still high (b2b=1). IR is presented as loaded at the end of T2.
    task automatic issue(input logic [31:0] ir, input int stalls, input bit keep_run,
                         input bit b2b, input string tag);
        logic [4:0]  op;
        logic [15:0] ra_h, rb_h, rc_h;
        bit          ill, md;
        exp_t        e;
        op   = ir[31:27];
        ra_h = 16'h0001 << ir[26:23];
        rb_h = 16'h0001 << ir[22:19];
        rc_h = 16'h0001 << ir[18:15];
        ill  = (op > 5'b10000);
        md   = (op == 5'b01111) || (op == 5'b10000);
        e.ill    = ill;
        e.rin    = (ill || md) ? 16'h0000 : ra_h;
        e.cycles = (ill ? 4 : (md ? 7 : 6)) + stalls;
        e.lo     = md ? 1 : 0;
        e.hi     = md ? 1 : 0;
        e.rw     = (!ill && !md) ? 1 : 0;
        sb.push_back(e);

        if (!b2b) run = 1'b1;
        @(negedge clk);
        check({tag, "_t0"}, snap(), mk(F_T0, E_T0, 16'h0, 16'h0, 5'd0, BUSY));
        if (!keep_run) run = 1'b0;
        mem_wait = (stalls > 0);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            check({tag, "_t1_wait"}, snap(), mk(F_T1W, 7'd0, 16'h0, 16'h0, 5'd0, BUSY));
        end
        @(negedge clk);
        mem_wait = 1'b0;
        #1;
        check({tag, "_t1"}, snap(), mk(F_T1, E_T1, 16'h0, 16'h0, 5'd0, BUSY));
        @(negedge clk);
        check({tag, "_t2"}, snap(), mk(F_T2, 7'd0, 16'h0, 16'h0, 5'd0, BUSY));
        IR = ir;
        mem_wait = 1'b1;
        @(negedge clk);
        if (ill) begin
            check({tag, "_t3"}, snap(), mk(8'd0, 7'd0, 16'h0, 16'h0, 5'd0, ILL));
        end else begin
            check({tag, "_t3"}, snap(), mk(8'd0, E_T3, 16'h0, rb_h, 5'd0, BUSY));
            @(negedge clk);
            check({tag, "_t4"}, snap(), mk(8'd0, E_T4, 16'h0, rc_h, op, BUSY));
            @(negedge clk);
            if (!md) begin
                check({tag, "_t5"}, snap(), mk(8'd0, E_T5A, ra_h, 16'h0, 5'd0, DONE));
            end else begin
                check({tag, "_t5"}, snap(), mk(8'd0, E_T5M, 16'h0, 16'h0, 5'd0, BUSY));
                @(negedge clk);
                check({tag, "_t6"}, snap(), mk(8'd0, E_T6, 16'h0, 16'h0, 5'd0, DONE));
            end
        end
        mem_wait = 1'b0;
    endtask

    initial begin
        int lo0, hi0;
        clr = 1'b1; run = 1'b0; mem_wait = 1'b0; IR = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_idle", snap(), 55'd0);
        run = 1'b1;
        @(negedge clk);
        check("reset_holds", snap(), 55'd0);
        clr = 1'b0; run = 1'b0;
        @(negedge clk);
        check("idle_no_run", snap(), 55'd0);

        issue(I_ADD, 0, 1'b0, 1'b0, "add");
        @(negedge clk); check("add_idle", snap(), 55'd0);

        issue(I_DIV, 0, 1'b0, 1'b0, "div");
        @(negedge clk); check("div_idle", snap(), 55'd0);

        issue(I_ZERO, 3, 1'b0, 1'b0, "stall");
        @(negedge clk); check("stall_idle", snap(), 55'd0);

        issue(I_ILL, 0, 1'b0, 1'b0, "ill");
        @(negedge clk); check("ill_idle", snap(), 55'd0);

        issue(I_ILL2, 0, 1'b0, 1'b0, "ill_lo");
        @(negedge clk); check("ill_lo_idle", snap(), 55'd0);

        issue(I_MUL, 0, 1'b1, 1'b0, "mul_b2b");
        issue(I_AMAX, 0, 1'b0, 1'b1, "alu_b2b");
        @(negedge clk); check("b2b_idle", snap(), 55'd0);

        // Abort a MUL in T4: nothing of it may ever reach HI or LO.
        lo0 = tot_lo;
        hi0 = tot_hi;
        run = 1'b1;
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        @(negedge clk); IR = I_MUL2;
        @(negedge clk);
        @(negedge clk);
        check("rst_t4", snap(), mk(8'd0, E_T4, 16'h0, 16'h0800, 5'b01111, BUSY));
        clr = 1'b1;
        @(negedge clk);
        check("rst_idle", snap(), 55'd0);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_still_idle", snap(), 55'd0);
        check("rst_no_lo", 64'(tot_lo - lo0), 64'd0);
        check("rst_no_hi", 64'(tot_hi - hi0), 64'd0);

        issue(I_ADD, 0, 1'b0, 1'b0, "restart");
        @(negedge clk); check("restart_idle", snap(), 55'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
